// File: rtl/matrix_scroll_src.sv
// Scrolling frame source for the 8x8 bicolour LED matrix: a column buffer loaded one column at
// a time, with an 8-column window stepped across it and presented as a row-major frame.
module matrix_scroll_src #(
    parameter int unsigned MAX_COLS = 64,
    parameter int unsigned STEP_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clear,
    input  logic        en,
    input  logic        pause,
    input  logic        dir,
    output logic [63:0] char,
    output logic        color,
    output logic        full,
    output logic        wrap
);

    localparam int unsigned AW = $clog2(MAX_COLS);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(STEP_DIV);
    localparam logic [LW-1:0] LenMax  = LW'(MAX_COLS);
    localparam logic [LW-1:0] WinCols = LW'(8);
    localparam logic [CW-1:0] CntMax  = CW'(STEP_DIV - 1);

    logic [7:0]    col_mem [MAX_COLS];
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          color_q, color_d;
    logic          wrap_q, wrap_d;
    logic          full_q;
    logic [63:0]   char_q, char_d;

    logic          do_write;
    logic          run;
    logic          step;
    logic [AW-1:0] step_pos;
    logic [LW-1:0] idx;
    logic [7:0]    col;

    assign do_write = wr_en && !full_q && !clear;
    assign run      = en && !pause && (len_q >= WinCols);
    assign step     = run && !clear && (cnt_q == CntMax);

    always_comb begin
        step_pos = pos_q;
        if (!dir) begin
            step_pos = (LW'(pos_q) == len_q - LW'(1)) ? '0 : pos_q + AW'(1);
        end else begin
            step_pos = (pos_q == '0) ? AW'(len_q - LW'(1)) : pos_q - AW'(1);
        end
    end

    // clear beats both the coincident write and any step
    always_comb begin
        len_d   = len_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        wrap_d  = 1'b0;
        if (clear) begin
            len_d = '0;
            pos_d = '0;
            cnt_d = '0;
        end else begin
            if (do_write) len_d = len_q + LW'(1);
            if (run) cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CW'(1);
            if (step) begin
                pos_d = step_pos;
                if (step_pos == '0) begin
                    wrap_d  = 1'b1;
                    color_d = ~color_q;
                end
            end
        end
    end

    // pos + c never exceeds 2*len-1 once len >= 8, so a single subtract gives the modulo;
    // below 8 columns pos stays 0 and columns past len read as blank
    always_comb begin
        char_d = '0;
        idx    = '0;
        col    = '0;
        for (int c = 0; c < 8; c++) begin
            idx = LW'(pos_q) + LW'(c);
            if (len_q >= WinCols && idx >= len_q) idx = idx - len_q;
            col = (idx < len_q) ? col_mem[idx[AW-1:0]] : 8'h00;
            for (int r = 0; r < 8; r++) begin
                char_d[63 - 8*r - c] = col[7-r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) col_mem[len_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            color_q <= 1'b0;
            wrap_q  <= 1'b0;
            full_q  <= 1'b0;
            char_q  <= '0;
        end else begin
            len_q   <= len_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            wrap_q  <= wrap_d;
            full_q  <= (len_d == LenMax);
            char_q  <= char_d;
        end
    end

    assign char  = char_q;
    assign color = color_q;
    assign full  = full_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_matrix_scroll_src.sv
// Self-checking bench for matrix_scroll_src: table of static messages through a scoreboard,
// plus cycle-by-cycle model comparisons for scrolling, pause, full, clear and async reset.
module tb_matrix_scroll_src;

    localparam int MaxCols = 64;
    localparam int StepDiv = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic        pause = 1'b0;
    logic        dir = 1'b0;
    logic [63:0] char;
    logic        color;
    logic        full;
    logic        wrap;

    matrix_scroll_src #(
        .MAX_COLS(MaxCols),
        .STEP_DIV(StepDiv)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .clear  (clear),
        .en     (en),
        .pause  (pause),
        .dir    (dir),
        .char   (char),
        .color  (color),
        .full   (full),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model of the message and scroll state
    logic [7:0] msg_m [MaxCols];
    int         len_m = 0;
    int         pos_m = 0;
    int         cnt_m = 0;
    logic       col_m = 1'b0;

    typedef struct {
        int          n;
        logic [63:0] cols;   // column k in cols[63-8k -: 8]
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [63:0] sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        len_m = 0;
        pos_m = 0;
        cnt_m = 0;
    endtask

    task automatic write_col(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (len_m < MaxCols) begin
            msg_m[len_m] = d;
            len_m++;
        end
    endtask

    function automatic logic [63:0] win(input int pos);
        logic [63:0] r;
        logic [7:0]  cv;
        int          ix;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            ix = (len_m >= 8) ? (pos + c) % len_m : c;
            cv = (ix < len_m) ? msg_m[ix] : 8'h00;
            for (int rr = 0; rr < 8; rr++) r[63 - 8*rr - c] = cv[7-rr];
        end
        return r;
    endfunction

    // inputs held constant; no writes or clears inside
    task automatic run_cycles(input int n, input string name);
        logic [63:0] exp_c;
        logic        stp;
        logic        exp_w;
        for (int i = 0; i < n; i++) begin
            tick();
            exp_c = win(pos_m);
            stp   = 1'b0;
            if (en && !pause && len_m >= 8) begin
                if (cnt_m == StepDiv - 1) begin
                    cnt_m = 0;
                    stp   = 1'b1;
                end else begin
                    cnt_m++;
                end
            end
            if (stp) begin
                if (!dir) pos_m = (pos_m == len_m - 1) ? 0 : pos_m + 1;
                else      pos_m = (pos_m == 0) ? len_m - 1 : pos_m - 1;
            end
            exp_w = stp && (pos_m == 0);
            if (exp_w) col_m = ~col_m;
            check({name, ".char"}, char, exp_c);
            check({name, ".wrap"}, {63'b0, wrap}, {63'b0, exp_w});
            check({name, ".color"}, {63'b0, color}, {63'b0, col_m});
        end
    endtask

    task automatic load_nine();
        do_clear();
        for (int k = 0; k < 8; k++) write_col(8'h00);
        write_col(8'hFF);
    endtask

    initial begin
        vecs[0] = '{8, 64'h8040201008040201, 64'h8040201008040201};
        vecs[1] = '{3, 64'hFFFFFF0000000000, 64'hE0E0E0E0E0E0E0E0};
        vecs[2] = '{8, 64'hAAAAAAAAAAAAAAAA, 64'hFF00FF00FF00FF00};
        vecs[3] = '{1, 64'h8100000000000000, 64'h8000000000000080};
        vecs[4] = '{5, 64'h0F0F0F0F0F000000, 64'h00000000F8F8F8F8};
        vecs[5] = '{8, 64'h0102040810204080, 64'h0102040810204080};
        vecs[6] = '{0, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};

        tick();
        tick();
        check("reset.char", char, 64'h0);
        check("reset.color", {63'b0, color}, 64'h0);
        check("reset.full", {63'b0, full}, 64'h0);
        check("reset.wrap", {63'b0, wrap}, 64'h0);
        rst = 1'b1;
        tick();

        // static messages, en=0
        foreach (vecs[i]) begin
            do_clear();
            for (int k = 0; k < vecs[i].n; k++) write_col(vecs[i].cols[63 - 8*k -: 8]);
            sb.push_back(vecs[i].exp);
            tick();
            check($sformatf("static%0d.char", i), char, sb.pop_front());
            check($sformatf("static%0d.full", i), {63'b0, full}, 64'h0);
        end

        // scroll left over 9 columns through one wrap
        load_nine();
        en  = 1'b1;
        dir = 1'b0;
        run_cycles(40, "left");

        // scroll right from pos 0; clear keeps color
        en = 1'b0;
        load_nine();
        check("clear.color", {63'b0, color}, {63'b0, col_m});
        en  = 1'b1;
        dir = 1'b1;
        run_cycles(40, "right");

        // pause mid-count
        run_cycles(2, "prepause");
        pause = 1'b1;
        run_cycles(20, "pause");
        pause = 1'b0;
        run_cycles(8, "resume");

        // short message never scrolls
        en = 1'b0;
        do_clear();
        for (int k = 0; k < 3; k++) write_col(8'hFF);
        en = 1'b1;
        run_cycles(12, "short");
        check("short.const", char, 64'hE0E0E0E0E0E0E0E0);

        // fill to capacity; 65th write is dropped
        en  = 1'b0;
        dir = 1'b0;
        do_clear();
        for (int k = 0; k < MaxCols; k++) begin
            write_col(8'(k * 37 + 1));
            if (k == MaxCols - 2) check("full.63", {63'b0, full}, 64'h0);
        end
        check("full.64", {63'b0, full}, 64'h1);
        write_col(8'hEE);
        check("full.65", {63'b0, full}, 64'h1);
        en = 1'b1;
        run_cycles(4 * MaxCols + 4, "fullscroll");

        // clear and write together
        en      = 1'b0;
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        len_m = 0;
        pos_m = 0;
        cnt_m = 0;
        check("clrwr.full", {63'b0, full}, 64'h0);
        run_cycles(3, "clrwr");

        // async reset mid-scroll
        load_nine();
        en = 1'b1;
        run_cycles(40, "prereset");
        #2;
        rst = 1'b0;
        #1;
        check("areset.char", char, 64'h0);
        check("areset.color", {63'b0, color}, 64'h0);
        check("areset.wrap", {63'b0, wrap}, 64'h0);
        tick();
        tick();
        rst   = 1'b1;
        len_m = 0;
        pos_m = 0;
        cnt_m = 0;
        col_m = 1'b0;
        run_cycles(10, "postreset");
        check("postreset.full", {63'b0, full}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
